// File: rtl/shift_reg_univ.sv
// Universal shift register: hold, shift right/left, parallel load,
// with a saturating shift counter and a serial pattern detector.
module shift_reg_univ #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] PATTERN = WIDTH'(8'hB2)
) (
  input  logic                         SR_CLK,
  input  logic                         SR_RST_N,
  input  logic                         SR_EN,
  input  logic [1:0]                   SR_MODE,
  input  logic                         SR_IN,
  input  logic [WIDTH-1:0]             SR_D,
  output logic [WIDTH-1:0]             SR_O,
  output logic                         SR_SO,
  output logic [$clog2(WIDTH+1)-1:0]   SR_CNT,
  output logic                         SR_FULL,
  output logic                         SR_MATCH
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  typedef enum logic [1:0] {
    M_HOLD  = 2'b00,
    M_RIGHT = 2'b01,
    M_LEFT  = 2'b10,
    M_LOAD  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] nxt_o;
  logic             nxt_so;
  logic [CW-1:0]    nxt_cnt;
  logic [CW-1:0]    inc_cnt;
  logic             shift;

  assign inc_cnt = (SR_CNT == CNT_MAX) ? CNT_MAX : SR_CNT + 1'b1;

  always_comb begin
    nxt_o   = SR_O;
    nxt_so  = SR_SO;
    nxt_cnt = SR_CNT;
    shift   = 1'b0;
    if (SR_EN) begin
      unique case (mode_e'(SR_MODE))
        M_RIGHT: begin
          nxt_o   = {SR_IN, SR_O[WIDTH-1:1]};
          nxt_so  = SR_O[0];
          nxt_cnt = inc_cnt;
          shift   = 1'b1;
        end
        M_LEFT: begin
          nxt_o   = {SR_O[WIDTH-2:0], SR_IN};
          nxt_so  = SR_O[WIDTH-1];
          nxt_cnt = inc_cnt;
          shift   = 1'b1;
        end
        M_LOAD: begin
          nxt_o   = SR_D;
          nxt_cnt = '0;
        end
        M_HOLD: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge SR_CLK or negedge SR_RST_N) begin
    if (!SR_RST_N) begin
      SR_O     <= '0;
      SR_SO    <= 1'b0;
      SR_CNT   <= '0;
      SR_MATCH <= 1'b0;
    end else begin
      SR_O     <= nxt_o;
      SR_SO    <= nxt_so;
      SR_CNT   <= nxt_cnt;
      // Only a real shift that completes a full window can flag a match
      SR_MATCH <= shift && (nxt_o == PATTERN) && (nxt_cnt == CNT_MAX);
    end
  end

  assign SR_FULL = (SR_CNT == CNT_MAX);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Randomized bench for shift_reg_univ against an arithmetic reference model,
// plus directed literal checks.
module tb_shift_reg_univ;

  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
  localparam logic [W-1:0] PAT = 8'hB2;
  localparam longint unsigned MASK = (64'd1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [1:0]    mode;
  logic          sin;
  logic [W-1:0]  d;
  logic [W-1:0]  o;
  logic          so;
  logic [CW-1:0] cnt;
  logic          full;
  logic          match;

  int vectors = 0;
  int errors  = 0;
  bit check_on = 0;

  longint unsigned m_o;
  int              m_so;
  int              m_cnt;
  int              m_match;

  shift_reg_univ #(.WIDTH(W), .PATTERN(PAT)) dut (
    .SR_CLK(clk), .SR_RST_N(rst_n), .SR_EN(en), .SR_MODE(mode),
    .SR_IN(sin), .SR_D(d), .SR_O(o), .SR_SO(so), .SR_CNT(cnt),
    .SR_FULL(full), .SR_MATCH(match)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_o = 0; m_so = 0; m_cnt = 0; m_match = 0;
  endtask

  task automatic model_edge(input bit e, input int md, input int b, input longint unsigned dv);
    bit shifted = 0;
    if (e) begin
      if (md == 1) begin
        m_so = int'(m_o & 1);
        m_o  = (m_o >> 1) | (longint'(b) << (W - 1));
        shifted = 1;
      end else if (md == 2) begin
        m_so = int'((m_o >> (W - 1)) & 1);
        m_o  = ((m_o << 1) | longint'(b)) & MASK;
        shifted = 1;
      end else if (md == 3) begin
        m_o = dv & MASK;
        m_cnt = 0;
      end
      if (shifted) m_cnt = (m_cnt < W) ? m_cnt + 1 : W;
    end
    m_match = (shifted && m_o == PAT && m_cnt == W) ? 1 : 0;
  endtask

  always @(negedge clk) begin
    if (check_on) begin
      vectors++;
      if (o !== W'(m_o) || so !== 1'(m_so) || cnt !== CW'(m_cnt) ||
          full !== (m_cnt == W) || match !== 1'(m_match)) begin
        errors++;
        $display("FAIL model: o=%h so=%b cnt=%0d full=%b match=%b expected o=%h so=%0d cnt=%0d full=%0d match=%0d at %0t",
                 o, so, cnt, full, match, m_o, m_so, m_cnt, (m_cnt == W), m_match, $time);
      end
    end
  end

  task automatic step(input bit e, input logic [1:0] md, input bit b, input logic [W-1:0] dv);
    en = e; mode = md; sin = b; d = dv;
    @(posedge clk);
    if (rst_n) model_edge(e, int'(md), int'(b), longint'(dv));
    #1;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_o", o, 0);
    chk("rst_so", so, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_full", full, 0);
    chk("rst_match", match, 0);
    rst_n = 1'b1;
  endtask

  logic [W-1:0] sv_o;
  logic         sv_so;
  logic [CW-1:0] sv_cnt;
  logic [7:0]   seq;

  initial begin
    rst_n = 1'b0; en = 0; mode = 0; sin = 0; d = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_o", o, 0);
    chk("reset_full", full, 0);
    step(1, 2'b01, 1, 8'h00);
    chk("edge_in_reset", o, 0);
    rst_n = 1'b1;
    check_on = 1;

    step(1, 2'b11, 0, 8'hA5);
    chk("load_o", o, 8'hA5);
    chk("load_cnt", cnt, 0);
    chk("load_full", full, 0);
    chk("load_match", match, 0);
    step(1, 2'b10, 1, 8'h00);
    chk("shl_o", o, 8'h4B);
    chk("shl_so", so, 1);
    step(1, 2'b11, 0, 8'hA5);
    step(1, 2'b01, 0, 8'h00);
    chk("shr_o", o, 8'h52);
    chk("shr_so", so, 1);

    do_reset();
    seq = 8'b1011_0010;
    for (int i = 0; i < 8; i++) step(1, 2'b01, seq[i], 8'h00);
    chk("seq_o", o, 8'hB2);
    chk("seq_cnt", cnt, 8);
    chk("seq_full", full, 1);
    chk("seq_match", match, 1);
    step(1, 2'b00, 0, 8'h00);
    chk("hold_match", match, 0);
    chk("hold_o", o, 8'hB2);

    step(1, 2'b11, 0, 8'hB2);
    chk("ldpat_match", match, 0);
    chk("ldpat_cnt", cnt, 0);
    for (int i = 0; i < 10; i++) step(1, 2'b01, 1'($urandom), 8'h00);
    chk("sat_cnt", cnt, 8);
    chk("sat_full", full, 1);

    sv_o = o; sv_so = so; sv_cnt = cnt;
    for (int i = 0; i < 5; i++) step(0, 2'b01, i[0], 8'hFF);
    chk("en0_o", o, sv_o);
    chk("en0_so", so, sv_so);
    chk("en0_cnt", cnt, sv_cnt);
    chk("en0_match", match, 0);

    do_reset();
    for (int i = 0; i < 4; i++) step(1, 2'b10, 1, 8'h00);
    chk("pre_rst_cnt", cnt, 4);
    do_reset();
    step(1, 2'b01, 1, 8'h00);
    chk("post_rst_cnt", cnt, 1);
    chk("post_rst_o", o, 8'h80);

    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [1:0] md;
      r = $urandom_range(0, 99);
      if (r < 40) md = 2'b01;
      else if (r < 80) md = 2'b10;
      else if (r < 88) md = 2'b00;
      else md = 2'b11;
      if ($urandom_range(0, 15) == 0) begin
        md = 2'b11;
        d = 8'(PAT >> $urandom_range(0, 3));
      end else d = 8'($urandom);
      step(($urandom_range(0, 9) != 0), md,
           (md == 2'b01) ? PAT[$urandom_range(0, 7)] : 1'($urandom), d);
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    check_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
SHIFT_REG_UNIV -- requirements
Module: shift_reg_univ

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 8, register width in bits (legal range 2..32).
REQ-002 The block SHALL expose parameter PATTERN, default 8'hB2 (WIDTH bits), the serial pattern to detect.
REQ-003 SR_CLK  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 SR_RST_N  input  1  asynchronous, active-low reset.
REQ-005 SR_EN  input  1  clock enable; 0 freezes all state.
REQ-006 SR_MODE  input  2  operation: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
REQ-007 SR_IN  input  1  serial data in.
REQ-008 SR_D  input  WIDTH  parallel load data.
REQ-009 SR_O  output  WIDTH  register contents, registered.
REQ-010 SR_SO  output  1  registered bit most recently shifted out.
REQ-011 SR_CNT  output  $clog2(WIDTH+1)  serial bits shifted in since the last load or reset, saturating.
REQ-012 SR_FULL  output  1  high when SR_CNT == WIDTH.
REQ-013 SR_MATCH  output  1  registered one-cycle detect pulse.

Function
REQ-014 Shift right (01, SR_EN=1): SR_O <= {SR_IN, SR_O[WIDTH-1:1]}; SR_SO <= old SR_O[0].
REQ-015 Shift left (10, SR_EN=1): SR_O <= {SR_O[WIDTH-2:0], SR_IN}; SR_SO <= old SR_O[WIDTH-1].
REQ-016 Parallel load (11, SR_EN=1): SR_O <= SR_D; SR_CNT <= 0; SR_SO unchanged.
REQ-017 Hold (00) or SR_EN=0: SR_O, SR_SO and SR_CNT SHALL keep their values.
REQ-018 Each shift SHALL increment SR_CNT by 1, saturating at WIDTH; further shifts keep SR_CNT == WIDTH with no wrap.
REQ-019 SR_FULL SHALL be decoded from the registered SR_CNT; no extra latency beyond SR_CNT.
REQ-020 SR_MATCH SHALL be 1 in exactly the cycle after an edge where a shift took place and both the post-shift SR_O == PATTERN and the post-shift SR_CNT == WIDTH; otherwise 0.
REQ-021 A load, a hold or SR_EN=0 SHALL drive SR_MATCH to 0 at the next edge, even when SR_O == PATTERN.
REQ-022 Consecutive matching shifts (for example, a periodic pattern) SHALL produce SR_MATCH high on consecutive cycles.
REQ-023 SR_IN and SR_D SHALL be sampled only at the rising edge; values between edges have no effect.
REQ-024 Latency: every operation SHALL be visible on the outputs one edge after it is sampled.

Reset
REQ-025 SR_RST_N=0 SHALL immediately, without a clock edge, force SR_O=0, SR_SO=0, SR_CNT=0, SR_FULL=0 and SR_MATCH=0.
REQ-026 While SR_RST_N=0, clock edges SHALL have no effect.
REQ-027 Operation SHALL resume at the first rising edge with SR_RST_N=1.
REQ-028 Reset asserted mid-stream SHALL discard partial serial data; no state survives.

Verification (WIDTH=8, PATTERN=8'hB2)
REQ-029 Reset, then SR_MODE=11, SR_D=8'hA5 for 1 edge -> SR_O=8'hA5, SR_CNT=0, SR_FULL=0, SR_MATCH=0.
REQ-030 From 8'hA5: SR_MODE=10, SR_IN=1 for 1 edge -> SR_O=8'h4B, SR_SO=1. Separately from 8'hA5: SR_MODE=01, SR_IN=0 for 1 edge -> SR_O=8'h52, SR_SO=1.
REQ-031 After reset, SR_MODE=01 with SR_IN sequence 0,1,0,0,1,1,0,1 -> after the 8th edge SR_O=8'hB2, SR_CNT=8, SR_FULL=1, SR_MATCH=1 for exactly one cycle; a following hold -> SR_MATCH=0.
REQ-032 Load 8'hB2 (SR_CNT=0) -> SR_MATCH stays 0. Ten further right shifts -> SR_CNT saturates at 8 and SR_FULL remains 1.
REQ-033 SR_EN=0 with SR_MODE=01 and SR_IN toggling for 5 edges -> SR_O, SR_SO and SR_CNT unchanged, SR_MATCH=0.
REQ-034 After 4 shifts, pulse SR_RST_N low between edges -> all outputs are 0 before the next edge. After release, the first shift gives SR_CNT=1.
